// File: rtl/carregador_de_instrucoes_pkg.sv
// ============================================================================
// Module      : carregador_de_instrucoes_pkg
// Description : Shared constants and state encodings for the program loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package carregador_de_instrucoes_pkg;

  // Shared with the processor's instruction memory depth
  localparam int c_NUM_PALAVRAS = 64;

  localparam logic [7:0] c_BYTE_SYNC = 8'hA5;

  localparam logic [2:0] c_ESPERA_SYNC  = 3'd0;
  localparam logic [2:0] c_LE_CONTAGEM  = 3'd1;
  localparam logic [2:0] c_LE_DADOS     = 3'd2;
  localparam logic [2:0] c_ESCREVE      = 3'd3;
  localparam logic [2:0] c_LE_CHECKSUM  = 3'd4;
  localparam logic [2:0] c_CONCLUIDO    = 3'd5;
  localparam logic [2:0] c_ERRO         = 3'd6;

endpackage

`default_nettype wire

// File: rtl/carregador_de_instrucoes_montador.sv
// ============================================================================
// Module      : montador_de_palavra
// Description : Little-endian 4-byte word assembler with end-of-word strobe.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module montador_de_palavra (
  input  logic        clk,
  input  logic        rst,
  input  logic        limpar_i,
  input  logic        byte_en_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] palavra_o,
  output logic        word_pronto_o
);

  logic [31:0] palavra_q;
  logic [1:0]  cnt_q;

  // First byte of the group shifts down to bits [7:0] after four shifts
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      palavra_q <= 32'd0;
      cnt_q     <= 2'd0;
    end else if (limpar_i) begin
      palavra_q <= 32'd0;
      cnt_q     <= 2'd0;
    end else if (byte_en_i) begin
      palavra_q <= {byte_i, palavra_q[31:8]};
      cnt_q     <= cnt_q + 2'd1;
    end
  end

  assign palavra_o     = palavra_q;
  assign word_pronto_o = byte_en_i && (cnt_q == 2'd3);

endmodule

`default_nettype wire

// File: rtl/carregador_de_instrucoes.sv
// ============================================================================
// Module      : carregador_de_instrucoes
// Description : Framed byte-serial loader filling instruction memory; holds
//               the core in reset until a checksum-verified load completes.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module carregador_de_instrucoes
  import carregador_de_instrucoes_pkg::*;
#(
  parameter int NUM_PALAVRAS = c_NUM_PALAVRAS,
  parameter int LARGURA_END  = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             byte_in,
  input  logic                   byte_valido,
  output logic                   byte_pronto,
  output logic                   mem_we,
  output logic [LARGURA_END-1:0] mem_end,
  output logic [31:0]            mem_dado,
  output logic                   cpu_rst,
  output logic                   concluido,
  output logic                   erro
);

  localparam logic [8:0] c_MAX_PALAVRAS = 9'(NUM_PALAVRAS);

  logic [2:0]             state_q, state_d;
  logic [7:0]             n_q, idx_q, chk_q;
  logic [LARGURA_END-1:0] end_q;
  logic [31:0]            dado_q;

  logic        w_aceita, w_conta_invalida, w_ultima;
  logic        w_carrega, w_byte_dado, w_word_pronto;
  logic [31:0] w_palavra;

  assign w_aceita         = byte_valido && byte_pronto;
  assign w_conta_invalida = (byte_in == 8'd0) || ({1'b0, byte_in} > c_MAX_PALAVRAS);
  assign w_ultima         = (idx_q + 8'd1) == n_q;
  assign w_carrega        = w_aceita && (state_q == c_LE_CONTAGEM) && !w_conta_invalida;
  assign w_byte_dado      = w_aceita && (state_q == c_LE_DADOS);

  montador_de_palavra u_montador (
    .clk           (clk),
    .rst           (rst),
    .limpar_i      (w_carrega),
    .byte_en_i     (w_byte_dado),
    .byte_i        (byte_in),
    .palavra_o     (w_palavra),
    .word_pronto_o (w_word_pronto)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= c_ESPERA_SYNC;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_ESPERA_SYNC: if (w_aceita && byte_in == c_BYTE_SYNC) state_d = c_LE_CONTAGEM;
      c_LE_CONTAGEM: if (w_aceita) state_d = w_conta_invalida ? c_ERRO : c_LE_DADOS;
      c_LE_DADOS:    if (w_word_pronto) state_d = c_ESCREVE;
      c_ESCREVE:     state_d = w_ultima ? c_LE_CHECKSUM : c_LE_DADOS;
      c_LE_CHECKSUM: if (w_aceita) state_d = (byte_in == chk_q) ? c_CONCLUIDO : c_ERRO;
      c_CONCLUIDO:   state_d = c_CONCLUIDO;
      c_ERRO:        state_d = c_ERRO;
      default:       state_d = c_ERRO;
    endcase
  end

  always_comb begin
    byte_pronto = 1'b0;
    mem_we      = 1'b0;
    cpu_rst     = 1'b1;
    concluido   = 1'b0;
    erro        = 1'b0;
    case (state_q)
      c_ESPERA_SYNC, c_LE_CONTAGEM, c_LE_DADOS, c_LE_CHECKSUM: byte_pronto = 1'b1;
      c_ESCREVE:   mem_we = 1'b1;
      c_CONCLUIDO: begin
        concluido = 1'b1;
        cpu_rst   = 1'b0;
      end
      c_ERRO:      erro = 1'b1;
      default:     ;
    endcase
  end

  // Address/data track the live values during ESCREVE and hold them afterwards
  assign mem_end  = (state_q == c_ESCREVE) ? LARGURA_END'(idx_q) : end_q;
  assign mem_dado = (state_q == c_ESCREVE) ? w_palavra : dado_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      n_q    <= 8'd0;
      idx_q  <= 8'd0;
      chk_q  <= 8'd0;
      end_q  <= '0;
      dado_q <= 32'd0;
    end else begin
      if (w_carrega) begin
        n_q   <= byte_in;
        idx_q <= 8'd0;
        chk_q <= 8'd0;
      end
      if (w_byte_dado) chk_q <= chk_q ^ byte_in;
      if (state_q == c_ESCREVE) begin
        idx_q  <= idx_q + 8'd1;
        end_q  <= LARGURA_END'(idx_q);
        dado_q <= w_palavra;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_carregador_de_instrucoes.sv
// ============================================================================
// Module      : tb_carregador_de_instrucoes
// Description : Scoreboard bench for the instruction loader.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_carregador_de_instrucoes;

  localparam int c_NP = 64;
  localparam int c_LE = 6;

  logic            clk = 1'b0;
  logic            rst = 1'b0;
  logic [7:0]      byte_in = 8'd0;
  logic            byte_valido = 1'b0;
  logic            byte_pronto, mem_we, cpu_rst, concluido, erro;
  logic [c_LE-1:0] mem_end;
  logic [31:0]     mem_dado;

  carregador_de_instrucoes #(.NUM_PALAVRAS(c_NP), .LARGURA_END(c_LE)) dut (
    .clk(clk), .rst(rst), .byte_in(byte_in), .byte_valido(byte_valido),
    .byte_pronto(byte_pronto), .mem_we(mem_we), .mem_end(mem_end),
    .mem_dado(mem_dado), .cpu_rst(cpu_rst), .concluido(concluido), .erro(erro)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [c_LE-1:0] a;
    logic [31:0]     d;
  } wr_t;

  wr_t        sb[$];
  wr_t        e_mon;
  logic [7:0] frame[$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         we_count = 0;
  logic [7:0] fixos [8] = '{8'h93, 8'h00, 8'h10, 8'h00, 8'h13, 8'h81, 8'h20, 8'h00};

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      we_count++;
      verifica("pronto_em_escreve", {31'd0, byte_pronto}, 32'd0);
      if (sb.size() == 0) begin
        verifica("escrita_inesperada", 32'd1, 32'd0);
      end else begin
        e_mon = sb.pop_front();
        verifica("mem_end", {26'd0, mem_end}, {26'd0, e_mon.a});
        verifica("mem_dado", mem_dado, e_mon.d);
      end
    end
  end

  // Called at a falling edge; returns at the falling edge after acceptance
  task automatic envia_byte(input logic [7:0] b, input bit lacunas);
    bit ok, aceito;
    aceito = 1'b0;
    if (lacunas) begin
      byte_valido = 1'b0;
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    byte_in     = b;
    byte_valido = 1'b1;
    for (int t = 0; t < 20; t++) begin
      ok = byte_pronto;
      @(posedge clk);
      if (ok) begin
        aceito = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!aceito) verifica("timeout_aceite", 32'd0, 32'd1);
    @(negedge clk);
  endtask

  task automatic envia_frame(input bit lacunas);
    foreach (frame[i]) envia_byte(frame[i], lacunas);
    byte_valido = 1'b0;
  endtask

  task automatic monta_frame(input int n, input bit aleat, input bit chk_ruim);
    logic [7:0]  b, x;
    logic [31:0] w;
    frame.delete();
    frame.push_back(8'hA5);
    frame.push_back(8'(n));
    x = 8'd0;
    for (int p = 0; p < n; p++) begin
      for (int k = 0; k < 4; k++) begin
        b = aleat ? 8'($urandom) : fixos[(p*4 + k) % 8];
        w[8*k +: 8] = b;
        x = x ^ b;
        frame.push_back(b);
      end
      sb.push_back({c_LE'(p), w});
    end
    frame.push_back(chk_ruim ? (x ^ 8'h01) : x);
  endtask

  task automatic confere_reset(input string tag);
    verifica({tag, "_pronto"},    {31'd0, byte_pronto}, 32'd1);
    verifica({tag, "_we"},        {31'd0, mem_we},      32'd0);
    verifica({tag, "_end"},       {26'd0, mem_end},     32'd0);
    verifica({tag, "_dado"},      mem_dado,             32'd0);
    verifica({tag, "_cpu_rst"},   {31'd0, cpu_rst},     32'd1);
    verifica({tag, "_concluido"}, {31'd0, concluido},   32'd0);
    verifica({tag, "_erro"},      {31'd0, erro},        32'd0);
  endtask

  task automatic aplica_reset();
    byte_valido = 1'b0;
    rst = 1'b1;
    #1;
    sb.delete();
    we_count = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic confere_fim(input string tag, input bit ok, input int escritas);
    verifica({tag, "_concluido"}, {31'd0, concluido},   {31'd0, ok});
    verifica({tag, "_erro"},      {31'd0, erro},        {31'd0, !ok});
    verifica({tag, "_cpu_rst"},   {31'd0, cpu_rst},     {31'd0, !ok});
    verifica({tag, "_pronto"},    {31'd0, byte_pronto}, 32'd0);
    verifica({tag, "_pendentes"}, sb.size(),            32'd0);
    verifica({tag, "_escritas"},  we_count,             escritas);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1 confere_reset("reset_inicial");
    @(negedge clk);
    rst = 1'b0;

    monta_frame(2, 1'b0, 1'b0);
    envia_frame(1'b0);
    confere_fim("carga_boa", 1'b1, 2);

    aplica_reset();
    monta_frame(2, 1'b0, 1'b1);
    envia_frame(1'b0);
    confere_fim("checksum_ruim", 1'b0, 2);

    aplica_reset();
    envia_byte(8'hA5, 1'b0);
    envia_byte(8'h00, 1'b0);
    byte_valido = 1'b0;
    repeat (3) @(negedge clk);
    confere_fim("contagem_zero", 1'b0, 0);

    aplica_reset();
    envia_byte(8'hA5, 1'b0);
    envia_byte(8'h41, 1'b0);
    byte_valido = 1'b0;
    repeat (3) @(negedge clk);
    confere_fim("contagem_65", 1'b0, 0);

    aplica_reset();
    envia_byte(8'h00, 1'b0);
    envia_byte(8'hFF, 1'b0);
    envia_byte(8'h5A, 1'b0);
    monta_frame(2, 1'b0, 1'b0);
    envia_frame(1'b0);
    confere_fim("lixo_antes_sync", 1'b1, 2);

    aplica_reset();
    monta_frame(2, 1'b0, 1'b0);
    envia_frame(1'b1);
    confere_fim("lacunas", 1'b1, 2);

    aplica_reset();
    monta_frame(5, 1'b1, 1'b0);
    envia_frame(1'b1);
    confere_fim("aleatorio_5", 1'b1, 5);

    aplica_reset();
    monta_frame(c_NP, 1'b1, 1'b0);
    envia_frame(1'b0);
    confere_fim("memoria_cheia", 1'b1, c_NP);

    aplica_reset();
    monta_frame(2, 1'b0, 1'b0);
    for (int i = 0; i < 8; i++) envia_byte(frame[i], 1'b0);
    verifica("meio_escritas", we_count, 32'd1);
    rst = 1'b1;
    #1 confere_reset("reset_meio");
    byte_valido = 1'b0;
    sb.delete();
    we_count = 0;
    @(negedge clk);
    rst = 1'b0;
    monta_frame(2, 1'b0, 1'b0);
    envia_frame(1'b0);
    confere_fim("apos_reset_meio", 1'b1, 2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
